id_hazard_ctrl: RTL and testbench

ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

---
 rtl/id_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_id_hazard_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_ctrl.sv
// ID-stage scoreboard hazard control: per-register pending-write counters, issue/stall/kill
// decision and a saturating stall counter. Define HAZARD_WB_BYPASS_EN to let WB-cycle sources issue.

module id_sb_cnt #(
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_inc,
    input  logic            i_dec,
    output logic [CNTW-1:0] o_cnt
);
    localparam logic [CNTW-1:0] ONE = CNTW'(1);

    logic [CNTW-1:0] r_cnt;
    logic            w_dec;

    // A WB to an idle register is stale and must not underflow the count
    assign w_dec = i_dec && (r_cnt != '0);
    assign o_cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_inc && !w_dec)
            r_cnt <= r_cnt + ONE;
        else if (!i_inc && w_dec)
            r_cnt <= r_cnt - ONE;
    end
endmodule

module id_hazard_ctrl #(
    parameter int NREG = 32,
    parameter int CNTW = 2,
    parameter int PCW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_id_valid,
    input  logic [4:0]      i_id_rs1_addr,
    input  logic [4:0]      i_id_rs2_addr,
    input  logic            i_id_rs1_used,
    input  logic            i_id_rs2_used,
    input  logic [4:0]      i_id_rd_addr,
    input  logic            i_id_rd_wen,
    input  logic            i_ex_ready,
    input  logic            i_flush,
    input  logic            i_wb_wr_reg_en,
    input  logic [4:0]      i_wb_wr_reg_addr,
    output logic            o_id_issue,
    output logic            o_id_stall,
    output logic            o_id_kill,
    output logic            o_bypass_a,
    output logic            o_bypass_b,
    output logic [NREG-1:0] o_sb_busy,
    output logic [PCW-1:0]  o_stall_cnt
);
    localparam int              AW   = 5;
    localparam logic [CNTW-1:0] CMAX = {CNTW{1'b1}};

    typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_t;

    state_t                     r_state;
    logic [PCW-1:0]             r_stall_cnt;
    logic [NREG-1:0][CNTW-1:0]  w_cnt;
    logic [CNTW-1:0]            w_cnt_rs1, w_cnt_rs2, w_cnt_rd;
    logic                       w_byp_a, w_byp_b;
    logic                       w_hz_a, w_hz_b, w_hz_st, w_hazard;
    logic                       w_kill, w_issue, w_stall, w_inc_rd;

    assign w_cnt[0] = '0;

    generate
        for (genvar r = 1; r < NREG; r++) begin : g_cnt
            id_sb_cnt #(.CNTW(CNTW)) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .i_inc (w_inc_rd && (i_id_rd_addr == AW'(r))),
                .i_dec (i_wb_wr_reg_en && (i_wb_wr_reg_addr == AW'(r))),
                .o_cnt (w_cnt[r])
            );
        end
        for (genvar r = 0; r < NREG; r++) begin : g_busy
            assign o_sb_busy[r] = |w_cnt[r];
        end
    endgenerate

    assign w_cnt_rs1 = w_cnt[i_id_rs1_addr];
    assign w_cnt_rs2 = w_cnt[i_id_rs2_addr];
    assign w_cnt_rd  = w_cnt[i_id_rd_addr];

`ifdef HAZARD_WB_BYPASS_EN
    // Last outstanding write lands this cycle: forward WB data instead of stalling
    assign w_byp_a = i_id_rs1_used && (i_id_rs1_addr != '0) && (w_cnt_rs1 == CNTW'(1)) &&
                     i_wb_wr_reg_en && (i_wb_wr_reg_addr == i_id_rs1_addr);
    assign w_byp_b = i_id_rs2_used && (i_id_rs2_addr != '0) && (w_cnt_rs2 == CNTW'(1)) &&
                     i_wb_wr_reg_en && (i_wb_wr_reg_addr == i_id_rs2_addr);
`else
    assign w_byp_a = 1'b0;
    assign w_byp_b = 1'b0;
`endif

    assign w_hz_a   = i_id_rs1_used && (i_id_rs1_addr != '0) && (w_cnt_rs1 != '0) && !w_byp_a;
    assign w_hz_b   = i_id_rs2_used && (i_id_rs2_addr != '0) && (w_cnt_rs2 != '0) && !w_byp_b;
    assign w_hz_st  = i_id_rd_wen && (i_id_rd_addr != '0) && (w_cnt_rd == CMAX);
    assign w_hazard = w_hz_a || w_hz_b || w_hz_st;

    assign w_kill   = i_flush || (r_state == S_FLUSH);
    assign w_issue  = i_id_valid && i_ex_ready && !w_hazard && !w_kill;
    assign w_stall  = i_id_valid && !w_issue && !w_kill;
    assign w_inc_rd = w_issue && i_id_rd_wen && (i_id_rd_addr != '0);

    assign o_id_issue  = w_issue;
    assign o_id_stall  = w_stall;
    assign o_id_kill   = w_kill;
    assign o_bypass_a  = w_byp_a;
    assign o_bypass_b  = w_byp_b;
    assign o_stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            case (r_state)
                S_RUN:
                    if (i_flush)
                        r_state <= S_FLUSH;
                    else if (i_id_valid && (w_hazard || !i_ex_ready))
                        r_state <= S_STALL;
                S_STALL:
                    if (i_flush)
                        r_state <= S_FLUSH;
                    else if (!(i_id_valid && w_hazard) && i_ex_ready)
                        r_state <= S_RUN;
                default:
                    r_state <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_stall && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + PCW'(1);
    end
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed and randomized bench for id_hazard_ctrl against a count-based scoreboard model.
module tb_id_hazard_ctrl;
    localparam int NREG = 32;
    localparam int CMAX = 3;
    localparam int SMAX = 65535;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_id_valid, i_id_rs1_used, i_id_rs2_used, i_id_rd_wen;
    logic [4:0]      i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr, i_wb_wr_reg_addr;
    logic            i_ex_ready, i_flush, i_wb_wr_reg_en;
    logic            o_id_issue, o_id_stall, o_id_kill, o_bypass_a, o_bypass_b;
    logic [NREG-1:0] o_sb_busy;
    logic [15:0]     o_stall_cnt;

    int checks = 0;
    int failures = 0;
    int pend[NREG];
    bit in_flush;
    int scnt;
    logic l_issue, l_stall, l_kill, l_byp_a;

    always #5 clk = ~clk;

    id_hazard_ctrl #(.NREG(NREG), .CNTW(2), .PCW(16)) dut (
        .clk(clk), .rst(rst),
        .i_id_valid(i_id_valid),
        .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
        .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
        .i_id_rd_addr(i_id_rd_addr), .i_id_rd_wen(i_id_rd_wen),
        .i_ex_ready(i_ex_ready), .i_flush(i_flush),
        .i_wb_wr_reg_en(i_wb_wr_reg_en), .i_wb_wr_reg_addr(i_wb_wr_reg_addr),
        .o_id_issue(o_id_issue), .o_id_stall(o_id_stall), .o_id_kill(o_id_kill),
        .o_bypass_a(o_bypass_a), .o_bypass_b(o_bypass_b),
        .o_sb_busy(o_sb_busy), .o_stall_cnt(o_stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_byp(input logic [4:0] a, input bit u, input bit wbe, input logic [4:0] wba);
`ifdef HAZARD_WB_BYPASS_EN
        return u && a != 0 && pend[a] == 1 && wbe && wba == a;
`else
        return 1'b0;
`endif
    endfunction

    // One cycle: drive, check outputs against the model, clock, advance the model.
    task automatic step(input bit r, input bit v,
                        input logic [4:0] a1, input bit u1, input logic [4:0] a2, input bit u2,
                        input logic [4:0] rd, input bit wen, input bit rdy, input bit fl,
                        input bit wbe, input logic [4:0] wba);
        bit ba, bb, ha, hb, st, kill, iss, stl, inc, dec;
        logic [NREG-1:0] esb;
        rst = r; i_id_valid = v;
        i_id_rs1_addr = a1; i_id_rs1_used = u1; i_id_rs2_addr = a2; i_id_rs2_used = u2;
        i_id_rd_addr = rd; i_id_rd_wen = wen; i_ex_ready = rdy; i_flush = fl;
        i_wb_wr_reg_en = wbe; i_wb_wr_reg_addr = wba;
        #2;
        ba   = m_byp(a1, u1, wbe, wba);
        bb   = m_byp(a2, u2, wbe, wba);
        ha   = u1 && a1 != 0 && pend[a1] != 0 && !ba;
        hb   = u2 && a2 != 0 && pend[a2] != 0 && !bb;
        st   = wen && rd != 0 && pend[rd] == CMAX;
        kill = fl || in_flush;
        iss  = v && rdy && !ha && !hb && !st && !kill;
        stl  = v && !iss && !kill;
        for (int i = 0; i < NREG; i++) esb[i] = (pend[i] != 0);
        chk("issue", o_id_issue, iss);
        chk("stall", o_id_stall, stl);
        chk("kill", o_id_kill, kill);
        chk("byp_a", o_bypass_a, ba);
        chk("byp_b", o_bypass_b, bb);
        chk("sb_busy", o_sb_busy, esb);
        chk("stall_cnt", o_stall_cnt, scnt);
        l_issue = o_id_issue; l_stall = o_id_stall; l_kill = o_id_kill; l_byp_a = o_bypass_a;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < NREG; i++) pend[i] = 0;
            scnt = 0; in_flush = 0;
        end else begin
            dec = wbe && wba != 0 && pend[wba] != 0;
            inc = iss && wen && rd != 0;
            if (dec) pend[wba]--;
            if (inc) pend[rd]++;
            if (stl && scnt != SMAX) scnt++;
            in_flush = fl && !in_flush;
        end
        #1;
    endtask

    task automatic idle(input bit wbe, input logic [4:0] wba);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, wbe, wba);
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) pend[i] = 0;
        in_flush = 0; scnt = 0;
        rst = 1; i_id_valid = 0; i_id_rs1_addr = 0; i_id_rs2_addr = 0;
        i_id_rs1_used = 0; i_id_rs2_used = 0; i_id_rd_addr = 0; i_id_rd_wen = 0;
        i_ex_ready = 1; i_flush = 0; i_wb_wr_reg_en = 0; i_wb_wr_reg_addr = 0;
        repeat (2) @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("rst_busy", o_sb_busy, 0);
        chk("rst_scnt", o_stall_cnt, 0);
        chk("rst_kill", l_kill, 0);

        // RAW on x5 resolved by writeback
        step(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        chk("raw_iss_w", l_issue, 1);
        step(0, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("raw_stall", l_stall, 1);
        step(0, 1, 5, 1, 0, 0, 0, 0, 1, 0, 1, 5);
`ifdef HAZARD_WB_BYPASS_EN
        chk("raw_wb_iss", l_issue, 1);
        chk("raw_wb_byp", l_byp_a, 1);
        chk("raw_scnt", o_stall_cnt, 1);
`else
        chk("raw_wb_stall", l_stall, 1);
        chk("raw_wb_byp", l_byp_a, 0);
        step(0, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("raw_late_iss", l_issue, 1);
        chk("raw_late_byp", l_byp_a, 0);
        chk("raw_scnt", o_stall_cnt, 2);
`endif

        // Counter saturation on x7: fourth writer waits for one WB
        repeat (3) step(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
        chk("sat_stall", l_stall, 1);
        step(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 1, 7);
        chk("sat_wb_stall", l_stall, 1);
        step(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
        chk("sat_iss", l_issue, 1);
        chk("sat_busy7", o_sb_busy[7], 1);

        // Flush while stalled: two kill cycles, then back to issuing
        step(0, 1, 7, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("fl_pre_stall", l_stall, 1);
        step(0, 1, 7, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("fl_kill1", l_kill, 1);
        chk("fl_noiss1", l_issue, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("fl_kill2", l_kill, 1);
        chk("fl_noiss2", l_issue, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("fl_run_iss", l_issue, 1);
        chk("fl_busy7", o_sb_busy[7], 1);
        repeat (3) idle(1, 7);

        // x0 traffic never creates hazards
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0, 1, 0, 1, 0, 1, 1, 0, k[0], 0);
            chk("x0_stall", l_stall, 0);
            chk("x0_busy0", o_sb_busy[0], 0);
        end

        // Reset mid-operation drops pending writes to x3
        repeat (2) step(0, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
        chk("mr_busy3", o_sb_busy[3], 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("mr_busy", o_sb_busy, 0);
        chk("mr_scnt", o_stall_cnt, 0);
        step(0, 1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("mr_iss", l_issue, 1);

        // Randomized traffic on a small register window
        for (int k = 0; k < 500; k++) begin
            step($urandom_range(99) == 0, $urandom_range(3) != 0,
                 5'($urandom_range(7)), $urandom_range(1) == 1,
                 5'($urandom_range(7)), $urandom_range(1) == 1,
                 5'($urandom_range(7)), $urandom_range(2) != 0,
                 $urandom_range(4) != 0, $urandom_range(19) == 0,
                 $urandom_range(1) == 1, 5'($urandom_range(7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
